// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the FSM state encoding that the
// receiver and transmitter agree on.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;
    // Tick index within a bit period at which the line is sampled (mid-bit).
    localparam int unsigned MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both stages reset
// to 1 so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_d;
    logic [1:0] sync_q;

    // Shift the raw line one stage per clock.
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Synchronizer flops, idle-high on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_BITS data bits LSB first, parity,
// stop. The line is sampled once per bit at tick MID_SAMPLE of the bit period.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int unsigned DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 sample_tick,
    input  logic                 p_sel,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] CntMid  = CntW'(MID_SAMPLE);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_e state_d, state_q;

    logic [CntW-1:0]      tick_cnt_d, tick_cnt_q;
    logic [IdxW-1:0]      bit_idx_d, bit_idx_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic                 armed_d, armed_q;
    logic                 perr_pend_d, perr_pend_q;
    logic [DATA_BITS-1:0] data_out_d, data_out_q;
    logic                 data_valid_d, data_valid_q;
    logic                 parity_err_d, parity_err_q;
    logic                 frame_err_d, frame_err_q;

    logic            mid;
    logic [CntW-1:0] tick_inc;

    assign mid      = (tick_cnt_q == CntMid);
    assign tick_inc = (tick_cnt_q == CntLast) ? '0 : tick_cnt_q + 1'b1;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; only a sample_tick can move the machine.
    always_comb begin
        state_d = state_q;
        if (sample_tick) begin
            unique case (state_q)
                StIdle:   if (armed_q && !rx_s) state_d = StStart;
                StStart:  if (mid) state_d = rx_s ? StIdle : StData;
                StData:   if (mid && (bit_idx_q == IdxLast)) state_d = StParity;
                StParity: if (mid) state_d = StStop;
                StStop:   if (mid) state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Datapath next state: counters, shift register, arming and result capture.
    // The tick counter is cleared at the start edge and then runs freely
    // through the frame, so every later count of MID_SAMPLE lands mid-bit.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        armed_d      = armed_q;
        perr_pend_d  = perr_pend_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        if (sample_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        armed_d    = 1'b0;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                    end
                end
                StStart: begin
                    tick_cnt_d = tick_inc;
                    if (mid) begin
                        bit_idx_d = '0;
                    end
                end
                StData: begin
                    tick_cnt_d = tick_inc;
                    if (mid) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = (bit_idx_q == IdxLast) ? '0 : bit_idx_q + 1'b1;
                    end
                end
                StParity: begin
                    tick_cnt_d = tick_inc;
                    if (mid) begin
                        perr_pend_d = rx_s != (p_sel ? ^shift_q : ~^shift_q);
                    end
                end
                StStop: begin
                    tick_cnt_d = tick_inc;
                    if (mid) begin
                        data_out_d   = shift_q;
                        parity_err_d = perr_pend_q;
                        frame_err_d  = !rx_s;
                        data_valid_d = 1'b1;
                    end
                end
                default: begin
                    tick_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b0;
            perr_pend_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            armed_q      <= armed_d;
            perr_pend_q  <= perr_pend_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, sample_tick pulses per bit period.
REQ-002 Parameter: DATA_BITS, 8, data bits per frame, LSB first.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-007 p_sel  input  1  parity select: 1 = parity bit equals XOR of data (even), 0 = its inverse (odd).
REQ-008 data_out  output  8  last received byte, held until next frame completes.
REQ-009 data_valid  output  1  one-clk pulse, frame complete; data_out and error flags valid.
REQ-010 parity_err  output  1  received parity bit mismatched; updated with data_valid, held.
REQ-011 frame_err  output  1  stop bit sampled low; updated with data_valid, held.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-014 Frame SHALL be: start (0), 8 data bits LSB first, parity bit, stop (1).
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; counters advance only on sample_tick.
REQ-016 IDLE: on sample_tick with armed=1 and synced rx=0 -> START, tick counter cleared.
REQ-017 armed SHALL set on any sample_tick seeing synced rx=1 and clear on leaving IDLE.
REQ-018 START: at tick count 7 (mid-bit), rx=0 -> DATA with counters cleared; rx=1 -> IDLE (false start, no outputs change).
REQ-019 DATA: each bit sampled at tick count 7 of its period, shifted in LSB first; after bit index 7 -> PARITY.
REQ-020 Bit-period tick counter SHALL wrap 15 -> 0; bit index SHALL wrap 7 -> 0 when leaving DATA.
REQ-021 PARITY: at mid-bit, parity_err_next = sampled bit != (p_sel ? ^data : ~^data); -> STOP.
REQ-022 STOP: at mid-bit, frame_err_next = (rx==0); -> IDLE on that same tick (no wait for bit end).
REQ-023 data_out, parity_err, frame_err, data_valid SHALL register on the clk edge after the stop mid-bit sample_tick (1 clk latency).
REQ-024 data_valid SHALL be high exactly one clk per completed frame, including errored frames.
REQ-025 After frame_err, a new start SHALL NOT be detected until rx is seen high (armed rule).
REQ-026 sample_tick absent: FSM holds state indefinitely; no timeout.
REQ-027 Back-to-back frames (stop immediately followed by start) SHALL be received without loss.

Reset
REQ-028 rst asserted (any time, incl. mid-frame) SHALL immediately force state IDLE, counters 0, shift register 0, armed 0.
REQ-029 Reset values: data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, busy=0; synchronizer flops=1.
REQ-030 A partially received frame at reset SHALL be discarded with no data_valid pulse.

Structure
REQ-031 Shared package uart_pkg SHALL hold state encoding (3-bit, shared with transmitter), DATA_BITS, OVERSAMPLE, MID_SAMPLE=7.
REQ-032 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, reset to 1); all else in uart_rx.
REQ-033 sample_tick SHALL be sourced at top level from the existing baud_tick generator instantiated at 16x BAUD_RATE.

Verification
REQ-034 Byte 0xA5, p_sel=1, parity bit 0, stop 1 -> data_out=0xA5, data_valid one clk, parity_err=0, frame_err=0.
REQ-035 Byte 0x3C, p_sel=0, parity bit sent 0 (expected 1) -> data_out=0x3C, parity_err=1, frame_err=0.
REQ-036 Byte 0x81, stop bit driven 0 then line held low 40 ticks -> frame_err=1; no new start until rx high, then 0x12 received clean.
REQ-037 rx low for 4 sample_ticks then high -> returns to IDLE, no data_valid, busy low after glitch.
REQ-038 rst pulse during data bit 3 of 0xF0 -> all outputs reset, no data_valid; following 0x5A received correctly.
REQ-039 Frames 0x00 then 0xFF back-to-back, p_sel=1 -> two data_valid pulses, values 0x00, 0xFF, no errors.
